// File: rtl/irq_timer_bank.sv
// irq_timer_bank: bank of periodic/one-shot timers with pending latches,
// fixed-priority interrupt id and saturating missed-tick counters.
module irq_timer_bank #(
    parameter int                NUM_CH    = 4,
    parameter int                CNT_W     = 16,
    parameter int                MISS_W    = 4,
    parameter int                RESET_LIM = 6249,
    parameter logic [NUM_CH-1:0] RESET_EN  = NUM_CH'(1),
    localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_lim,
    input  logic              cfg_en,
    input  logic              cfg_oneshot,
    input  logic [NUM_CH-1:0] ack,
    input  logic              miss_clr,
    output logic [NUM_CH-1:0] irq_pending,
    output logic              ei_req,
    output logic [CH_W-1:0]   irq_id,
    output logic [MISS_W-1:0] rd_missed
);
    logic [CNT_W-1:0]  lim_q    [NUM_CH];
    logic [CNT_W-1:0]  lim_d    [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [MISS_W-1:0] missed_q [NUM_CH];
    logic [MISS_W-1:0] missed_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d, oneshot_q, oneshot_d, pending_q, pending_d;
    logic [NUM_CH-1:0] tick, wr_sel, clr_sel;
    logic [MISS_W-1:0] rd_missed_q, rd_missed_d;
    logic              ch_ok;

    assign ch_ok = int'(cfg_ch) < NUM_CH;

    // A tick coinciding with a config write to the same channel is dropped.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_sel[c]    = cfg_we & ch_ok & (int'(cfg_ch) == c);
            clr_sel[c]   = miss_clr & ch_ok & (int'(cfg_ch) == c);
            tick[c]      = en_q[c] & (cnt_q[c] == lim_q[c]) & ~wr_sel[c];
            cnt_d[c]     = (wr_sel[c] | ~en_q[c] | tick[c]) ? '0 : cnt_q[c] + 1'b1;
            lim_d[c]     = wr_sel[c] ? cfg_lim : lim_q[c];
            en_d[c]      = wr_sel[c] ? cfg_en : en_q[c] & ~(tick[c] & oneshot_q[c]);
            oneshot_d[c] = wr_sel[c] ? cfg_oneshot : oneshot_q[c];
            pending_d[c] = ~ack[c] & (tick[c] | pending_q[c]);
            missed_d[c]  = clr_sel[c] ? '0 :
                           (tick[c] & (pending_q[c] | ack[c]) & ~&missed_q[c]) ? missed_q[c] + 1'b1 :
                           missed_q[c];
        end
        rd_missed_d = ch_ok ? missed_q[cfg_ch] : '0;
    end

    always_comb begin
        irq_id = '0;
        for (int c = NUM_CH - 1; c >= 0; c--)
            if (pending_q[c]) irq_id = CH_W'(c);
    end

    assign irq_pending = pending_q;
    assign ei_req      = |pending_q;
    assign rd_missed   = rd_missed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                lim_q[c]    <= CNT_W'(RESET_LIM);
                cnt_q[c]    <= '0;
                missed_q[c] <= '0;
            end
            en_q        <= RESET_EN;
            oneshot_q   <= '0;
            pending_q   <= '0;
            rd_missed_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                lim_q[c]    <= lim_d[c];
                cnt_q[c]    <= cnt_d[c];
                missed_q[c] <= missed_d[c];
            end
            en_q        <= en_d;
            oneshot_q   <= oneshot_d;
            pending_q   <= pending_d;
            rd_missed_q <= rd_missed_d;
        end
    end
endmodule

// File: tb/tb_irq_timer_bank.sv
// tb_irq_timer_bank: table-driven check of irq_timer_bank with default parameters;
// expected outputs are queued when a vector is driven and popped when sampled.
module tb_irq_timer_bank;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_lim = '0;
    logic        cfg_en = 1'b0;
    logic        cfg_oneshot = 1'b0;
    logic [3:0]  ack = '0;
    logic        miss_clr = 1'b0;
    logic [3:0]  irq_pending;
    logic        ei_req;
    logic [1:0]  irq_id;
    logic [3:0]  rd_missed;

    int checks = 0;
    int errors = 0;

    irq_timer_bank dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_lim(cfg_lim),
        .cfg_en(cfg_en), .cfg_oneshot(cfg_oneshot), .ack(ack), .miss_clr(miss_clr),
        .irq_pending(irq_pending), .ei_req(ei_req), .irq_id(irq_id), .rd_missed(rd_missed)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  ch;
        logic [15:0] lim;
        logic        en;
        logic        os;
        logic [3:0]  ack;
        logic        mclr;
        int          idle;
        logic [3:0]  pend;
        logic        ei;
        logic [1:0]  id;
        logic [3:0]  rd;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] pend;
        logic       ei;
        logic [1:0] id;
        logic [3:0] rd;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[24];

    function automatic vec_t mk(string n, logic we, logic [1:0] ch, logic [15:0] lim, logic en,
                                logic os, logic [3:0] a, logic mc, int idle,
                                logic [3:0] p, logic ei, logic [1:0] id, logic [3:0] rd);
        vec_t v;
        v.name = n; v.we = we; v.ch = ch; v.lim = lim; v.en = en; v.os = os; v.ack = a;
        v.mclr = mc; v.idle = idle; v.pend = p; v.ei = ei; v.id = id; v.rd = rd;
        return v;
    endfunction

    task automatic push_exp(string n, logic [3:0] p, logic ei, logic [1:0] id, logic [3:0] rd);
        exp_t e;
        e.name = n; e.pend = p; e.ei = ei; e.id = id; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic cmp(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic check_top();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: no expected entry queued");
        end else begin
            e = sb.pop_front();
            cmp({e.name, ".pending"}, 32'(irq_pending), 32'(e.pend));
            cmp({e.name, ".ei_req"}, 32'(ei_req), 32'(e.ei));
            cmp({e.name, ".irq_id"}, 32'(irq_id), 32'(e.id));
            cmp({e.name, ".rd_missed"}, 32'(rd_missed), 32'(e.rd));
        end
    endtask

    initial begin
        //            name          we ch lim   en os ack      mc idle pend     ei id rd
        tbl[0]  = mk("ch0_off",     1, 0, 6249, 0, 0, 4'b0001, 0, 0,  4'b0000, 0, 0, 0);
        tbl[1]  = mk("ch2_wr",      1, 2, 3,    1, 0, 4'b0000, 0, 3,  4'b0000, 0, 0, 0);
        tbl[2]  = mk("ch2_tick",    0, 2, 0,    0, 0, 4'b0000, 0, 0,  4'b0100, 1, 2, 0);
        tbl[3]  = mk("ch2_miss1",   0, 2, 0,    0, 0, 4'b0000, 0, 6,  4'b0100, 1, 2, 1);
        tbl[4]  = mk("ch2_miss2",   0, 2, 0,    0, 0, 4'b0000, 0, 0,  4'b0100, 1, 2, 1);
        tbl[5]  = mk("ch2_rd2",     0, 2, 0,    0, 0, 4'b0000, 0, 0,  4'b0100, 1, 2, 2);
        tbl[6]  = mk("ack2",        0, 2, 0,    0, 0, 4'b0100, 0, 0,  4'b0000, 0, 0, 2);
        tbl[7]  = mk("ch2_idle",    0, 2, 0,    0, 0, 4'b0000, 0, 0,  4'b0000, 0, 0, 2);
        tbl[8]  = mk("ack_tick",    0, 2, 0,    0, 0, 4'b0100, 0, 0,  4'b0000, 0, 0, 2);
        tbl[9]  = mk("ack_miss",    0, 2, 0,    0, 0, 4'b0000, 0, 0,  4'b0000, 0, 0, 3);
        tbl[10] = mk("ch2_off",     1, 2, 3,    0, 0, 4'b0000, 0, 0,  4'b0000, 0, 0, 3);
        tbl[11] = mk("ch1_os_wr",   1, 1, 0,    1, 1, 4'b0000, 0, 0,  4'b0000, 0, 0, 0);
        tbl[12] = mk("ch1_tick",    0, 1, 0,    0, 0, 4'b0000, 0, 0,  4'b0010, 1, 1, 0);
        tbl[13] = mk("ch1_stop",    0, 1, 0,    0, 0, 4'b0000, 0, 5,  4'b0010, 1, 1, 0);
        tbl[14] = mk("ch3_os_wr",   1, 3, 0,    1, 1, 4'b0000, 0, 0,  4'b0010, 1, 1, 0);
        tbl[15] = mk("ch3_tick",    0, 3, 0,    0, 0, 4'b0000, 0, 0,  4'b1010, 1, 1, 0);
        tbl[16] = mk("ack1",        0, 3, 0,    0, 0, 4'b0010, 0, 0,  4'b1000, 1, 3, 0);
        tbl[17] = mk("ack13",       0, 3, 0,    0, 0, 4'b1010, 0, 0,  4'b0000, 0, 0, 0);
        tbl[18] = mk("ch2_fast",    1, 2, 0,    1, 0, 4'b0000, 0, 0,  4'b0000, 0, 0, 3);
        tbl[19] = mk("saturate",    0, 2, 0,    0, 0, 4'b0000, 0, 19, 4'b0100, 1, 2, 15);
        tbl[20] = mk("clr_tick",    0, 2, 0,    0, 0, 4'b0000, 1, 0,  4'b0100, 1, 2, 15);
        tbl[21] = mk("after_clr",   0, 2, 0,    0, 0, 4'b0000, 0, 0,  4'b0100, 1, 2, 0);
        tbl[22] = mk("wr_drop",     1, 2, 0,    0, 0, 4'b0000, 0, 0,  4'b0100, 1, 2, 1);
        tbl[23] = mk("no_miss",     0, 2, 0,    0, 0, 4'b0000, 0, 0,  4'b0100, 1, 2, 1);

        repeat (2) @(negedge clk);
        push_exp("reset", 4'b0000, 0, 0, 0);
        check_top();
        reset = 1'b0;
        repeat (3000) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        push_exp("mid_reset", 4'b0000, 0, 0, 0);
        check_top();
        @(negedge clk);
        reset = 1'b0;
        repeat (6249) @(posedge clk);
        @(negedge clk);
        push_exp("pre_tick", 4'b0000, 0, 0, 0);
        check_top();
        @(posedge clk);
        @(negedge clk);
        push_exp("first_tick", 4'b0001, 1, 0, 0);
        check_top();

        foreach (tbl[i]) begin
            cfg_we = tbl[i].we; cfg_ch = tbl[i].ch; cfg_lim = tbl[i].lim; cfg_en = tbl[i].en;
            cfg_oneshot = tbl[i].os; ack = tbl[i].ack; miss_clr = tbl[i].mclr;
            push_exp(tbl[i].name, tbl[i].pend, tbl[i].ei, tbl[i].id, tbl[i].rd);
            @(posedge clk);
            for (int k = 0; k < tbl[i].idle; k++) begin
                @(negedge clk);
                cfg_we = 1'b0; miss_clr = 1'b0; ack = '0;
                @(posedge clk);
            end
            @(negedge clk);
            cfg_we = 1'b0; miss_clr = 1'b0; ack = '0;
            check_top();
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/irq_timer_bank.md
IRQ_TIMER_BANK -- requirements
Module: irq_timer_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of independent timer channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the period limit and counter.
REQ-003 The block SHALL have parameter MISS_W, default 4, meaning the width of the saturating missed-tick counter.
REQ-004 The block SHALL have parameter RESET_LIM, default 6249, meaning the period limit loaded at reset (8 kHz at 50 MHz).
REQ-005 The block SHALL have parameter RESET_EN, default NUM_CH'b1, meaning the channel enable mask loaded at reset.
REQ-006 The block SHALL have port clk, input, 1, the clock.
REQ-007 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have port cfg_we, input, 1, configuration write strobe.
REQ-009 The block SHALL have port cfg_ch, input, clog2(NUM_CH) (minimum 1), the target channel for configuration, read and clear.
REQ-010 The block SHALL have port cfg_lim, input, CNT_W, the period limit to write.
REQ-011 The block SHALL have port cfg_en, input, 1, the enable to write.
REQ-012 The block SHALL have port cfg_oneshot, input, 1, the mode to write (1 = one-shot, 0 = periodic).
REQ-013 The block SHALL have port ack, input, NUM_CH, level-sensitive per-channel acknowledge.
REQ-014 The block SHALL have port miss_clr, input, 1, a strobe that clears the missed count of cfg_ch.
REQ-015 The block SHALL have port irq_pending, output, NUM_CH, per-channel pending latches.
REQ-016 The block SHALL have port ei_req, output, 1, the OR of irq_pending.
REQ-017 The block SHALL have port irq_id, output, clog2(NUM_CH), the lowest-index pending channel (0 when none is pending).
REQ-018 The block SHALL have port rd_missed, output, MISS_W, the missed count of cfg_ch, registered.

Function
REQ-019 Each channel SHALL hold lim, en, oneshot, cnt, pending and missed registers.
REQ-020 When en=1, a channel's cnt SHALL increment each cycle and wrap to 0 on the cycle where cnt==lim; that cycle is a tick.
REQ-021 The tick period SHALL be lim+1 cycles; lim=0 SHALL tick every enabled cycle.
REQ-022 When en=0, cnt SHALL hold at 0, no ticks SHALL occur, and pending and missed SHALL retain their values.
REQ-023 On cfg_we, the selected channel SHALL load lim, en and oneshot and SHALL clear cnt to 0 on the next edge; a tick coinciding with the write SHALL be discarded.
REQ-024 In one-shot mode, the tick cycle SHALL also clear en, so the channel stops with cnt=0.
REQ-025 The pending register SHALL update as pending <= ~ack & (tick | pending), so ack held high keeps pending clear.
REQ-026 Missed SHALL increment, saturating at 2^MISS_W-1, on a tick that occurs while pending=1 or ack=1.
REQ-027 On miss_clr, missed for cfg_ch SHALL clear to 0; when miss_clr and a miss occur in the same cycle, the clear SHALL win.
REQ-028 rd_missed SHALL present missed[cfg_ch] one cycle after cfg_ch is applied, reflecting the pre-edge value.
REQ-029 irq_pending, ei_req and irq_id SHALL be combinational from the pending registers.
REQ-030 irq_id SHALL use fixed priority, with the lowest index winning.
REQ-031 cfg_ch values of NUM_CH or greater SHALL be ignored for writes and clears, and SHALL read as 0.

Reset
REQ-032 On reset, all cnt, pending, missed and oneshot registers, rd_missed and irq_id SHALL be 0, and ei_req SHALL be 0.
REQ-033 On reset, all lim registers SHALL be RESET_LIM and the en registers SHALL be RESET_EN.
REQ-034 Reset asserted mid-period SHALL abort the count; after release, the first tick of channel 0 SHALL occur on the (RESET_LIM+1)th edge.

Verification
REQ-035 Reset release with defaults -> ch0 pending rises after 6250 cycles; ch1..3 stay 0; ei_req=1 and irq_id=0.
REQ-036 Write ch2 with lim=3, periodic, ack=0 -> pending[2] sets 4 cycles later; next ticks at +4 and +8 increment missed[2] to 2; rd_missed reads 2.
REQ-037 Pulse ack[2] for 1 cycle when pending -> pending[2] clears the next cycle; a tick in the ack cycle gives pending=0 and missed+1.
REQ-038 Write ch1 with lim=0, one-shot -> exactly one tick and pending[1]=1; en[1] reads back as 0; no further ticks.
REQ-039 Channels 1 and 3 both pending -> irq_id=1; ack[1] high -> irq_id=3; ack[3] also high -> ei_req=0.
REQ-040 With MISS_W=4, 20 unacked ticks -> missed saturates at 15; miss_clr together with a tick -> missed=0.
